// File: rtl/pkmc_refresh_sched.sv
// pkmc_refresh_sched: SDRAM auto-refresh scheduler.
// Counts refresh intervals, tracks owed refreshes, requests the SDRAM path
// from the decoder and, once granted, issues PRECHARGE-ALL followed by
// back-to-back AUTO-REFRESH commands until nothing is owed.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   enable_i      - interval counting enable
//   irq_o         - refresh request to the decoder
//   irq_ack_i     - decoder grant of the SDRAM path
//   cmd_o         - SDRAM command (0 NOP, 1 PRECHARGE_ALL, 2 AUTO_REFRESH)
//   busy_o        - sequencer not idle
//   pending_o     - owed-refresh count
//   overflow_o    - sticky: tick lost while the owed count was saturated
module pkmc_refresh_sched #(
  parameter int unsigned REFRESH_PERIOD = 390,
  parameter int unsigned MAX_PENDING    = 8,
  parameter int unsigned TRP            = 2,
  parameter int unsigned TRFC           = 7,
  parameter int unsigned CNT_W          = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  output logic       irq_o,
  input  logic       irq_ack_i,
  output logic [1:0] cmd_o,
  output logic       busy_o,
  output logic [3:0] pending_o,
  output logic       overflow_o
);

  localparam int unsigned PEND_W   = 4;
  localparam int unsigned WAIT_MAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_PRE = 2'd1;
  localparam logic [1:0] CMD_REF = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_PRE      = 3'd2,
    S_WAIT_RP  = 3'd3,
    S_REF      = 3'd4,
    S_WAIT_RFC = 3'd5,
    S_RELEASE  = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                irq_q, irq_d;
  logic [1:0]          cmd_q, cmd_d;
  logic                busy_q, busy_d;
  logic                tick_c;
  logic                issue_c;

  // Interval counter: wraps at REFRESH_PERIOD-1, held at zero when disabled.
  always_comb begin
    tick_c = 1'b0;
    cnt_d  = '0;
    if (enable_i) begin
      if (cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // The registered command is what the SDRAM sees this cycle.
  assign issue_c = (cmd_q == CMD_REF);

  // Owed-refresh counter; a simultaneous tick and issue cancel out.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (tick_c && !issue_c) begin
      if (pend_q == PEND_W'(MAX_PENDING)) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (issue_c && !tick_c) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // Sequencer next state; outputs are decoded from the next state so the
  // registered outputs line up with the registered state.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    irq_d   = 1'b0;
    cmd_d   = CMD_NOP;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q != '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (irq_ack_i) state_d = S_PRE;
      end
      S_PRE: begin
        state_d = S_WAIT_RP;
        wait_d  = WAIT_W'(TRP - 1);
      end
      S_WAIT_RP: begin
        if (wait_q == '0) state_d = S_REF;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_REF: begin
        state_d = S_WAIT_RFC;
        wait_d  = WAIT_W'(TRFC - 1);
      end
      S_WAIT_RFC: begin
        // Drain further owed refreshes without a second precharge.
        if (wait_q == '0) state_d = (pend_d != '0) ? S_REF : S_RELEASE;
        else              wait_d  = wait_q - WAIT_W'(1);
      end
      S_RELEASE: begin
        if (!irq_ack_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_REQ, S_WAIT_RP, S_WAIT_RFC: irq_d = 1'b1;
      S_PRE: begin
        irq_d = 1'b1;
        cmd_d = CMD_PRE;
      end
      S_REF: begin
        irq_d = 1'b1;
        cmd_d = CMD_REF;
      end
      default: irq_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      wait_q  <= '0;
      irq_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
      irq_q   <= irq_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
    end
  end

  assign irq_o      = irq_q;
  assign cmd_o      = cmd_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule
